// File: rtl/csr_unit_pkg.sv
// +----------------------------------------------------------------------+
// | Module     : csr_unit_pkg                                            |
// | Description: Shared types and constants for the machine-mode CSR     |
// |              file: op modes, CSR addresses, mstatus bit positions    |
// |              and mcause codes.                                       |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

package csr_unit_pkg;

  typedef enum logic [1:0] {
    CSR_NONE = 2'd0,
    CSR_RW   = 2'd1,
    CSR_SET  = 2'd2,
    CSR_CLR  = 2'd3
  } csr_op_mode_t;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [31:0] MCAUSE_ILLEGAL_INSTR = 32'd2;
  localparam logic [31:0] MCAUSE_BREAKPOINT    = 32'd3;
  localparam logic [31:0] MCAUSE_ECALL_M       = 32'd11;

  // True for any of the eight counter addresses (machine or user shadow).
  function automatic logic is_counter_addr(input logic [11:0] addr);
    return (addr == CSR_MCYCLE)  || (addr == CSR_MCYCLEH)  ||
           (addr == CSR_MINSTRET)|| (addr == CSR_MINSTRETH)||
           (addr == CSR_CYCLE)   || (addr == CSR_CYCLEH)   ||
           (addr == CSR_INSTRET) || (addr == CSR_INSTRETH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/csr_unit_if.sv
// +----------------------------------------------------------------------+
// | Module     : csr_unit_if                                             |
// | Description: CSR request / trap signalling bundle between the        |
// |              decode-control logic (master) and csr_unit (slave).     |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

interface csr_unit_if;
  import csr_unit_pkg::*;

  logic         csr_r_en_i;
  csr_op_mode_t csr_op_mode_i;
  logic [11:0]  csr_addr_i;
  logic [31:0]  csr_wdata_i;
  logic [31:0]  csr_rdata_o;
  logic         csr_exception_o;
  logic         exception_i;
  logic [3:0]   excep_code_i;
  logic [31:0]  excep_pc_i;
  logic         ret_i;
  logic         retire_i;
  logic         trap_redirect_o;
  logic [31:0]  trap_pc_o;

  modport master (
    output csr_r_en_i, csr_op_mode_i, csr_addr_i, csr_wdata_i,
    output exception_i, excep_code_i, excep_pc_i, ret_i, retire_i,
    input  csr_rdata_o, csr_exception_o, trap_redirect_o, trap_pc_o
  );

  modport slave (
    input  csr_r_en_i, csr_op_mode_i, csr_addr_i, csr_wdata_i,
    input  exception_i, excep_code_i, excep_pc_i, ret_i, retire_i,
    output csr_rdata_o, csr_exception_o, trap_redirect_o, trap_pc_o
  );

endinterface

`default_nettype wire

// File: rtl/csr_unit_counter64.sv
// +----------------------------------------------------------------------+
// | Module     : csr_counter64                                           |
// | Description: 64-bit free-running counter with increment enable and   |
// |              independent low/high 32-bit write ports. Any write      |
// |              suppresses that cycle's increment for the whole counter.|
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module csr_counter64 (
  input  wire logic        clk_i,
  input  wire logic        rst_n_i,
  input  wire logic        inc_en,
  input  wire logic        lo_we,
  input  wire logic        hi_we,
  input  wire logic [31:0] wdata,
  output logic      [63:0] count
);

  logic [63:0] r_count;

  // Software writes take precedence over counting; the untouched half keeps its value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count <= 64'd0;
    end else if (lo_we || hi_we) begin
      if (lo_we) r_count[31:0]  <= wdata;
      if (hi_we) r_count[63:32] <= wdata;
    end else if (inc_en) begin
      r_count <= r_count + 64'd1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/csr_unit.sv
// +----------------------------------------------------------------------+
// | Module     : csr_unit                                                |
// | Description: Machine-mode CSR file and trap sequencer. Zicsr RMW in  |
// |              X, read data / illegal fault registered into M, and     |
// |              trap / mret redirect PC.                                |
// | Config     : CSR_COUNTERS_EN - implements mcycle/minstret (and the   |
// |              read-only cycle/instret shadows) as 64-bit counters.    |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module csr_unit
  import csr_unit_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input wire logic clk_i,
  input wire logic rst_n_i,
  csr_unit_if.slave bus
);

`ifdef CSR_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        r_mie, r_mpie;
  logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mcause;
  logic [31:0] r_rdata;
  logic        r_exc;

  logic [31:0] w_mstatus, w_old, w_new, w_cnt_rd;
  logic        w_impl, w_is_write, w_illegal, w_we;
  logic        w_take_trap, w_flush, w_mret;

  assign w_take_trap = bus.exception_i | r_exc;
  assign w_flush     = w_take_trap | bus.ret_i;
  assign w_mret      = bus.ret_i & ~w_take_trap;

  assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};

  // Read mux: old value of the addressed CSR and whether the address exists.
  always_comb begin
    w_old  = 32'd0;
    w_impl = 1'b1;
    case (bus.csr_addr_i)
      CSR_MSTATUS:  w_old = w_mstatus;
      CSR_MISA:     w_old = MISA_VAL;
      CSR_MTVEC:    w_old = r_mtvec;
      CSR_MSCRATCH: w_old = r_mscratch;
      CSR_MEPC:     w_old = r_mepc;
      CSR_MCAUSE:   w_old = r_mcause;
      CSR_MHARTID:  w_old = HART_ID;
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
      CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH:
                    w_old = w_cnt_rd;
      default:      w_impl = 1'b0;
    endcase
  end

  // Zicsr modify: SET/CLR with a zero operand is a pure read.
  always_comb begin
    w_is_write = 1'b0;
    w_new      = w_old;
    case (bus.csr_op_mode_i)
      CSR_RW:  begin w_is_write = 1'b1;                    w_new = bus.csr_wdata_i;          end
      CSR_SET: begin w_is_write = |bus.csr_wdata_i;        w_new = w_old | bus.csr_wdata_i;  end
      CSR_CLR: begin w_is_write = |bus.csr_wdata_i;        w_new = w_old & ~bus.csr_wdata_i; end
      default: begin w_is_write = 1'b0;                    w_new = w_old;                    end
    endcase
  end

  // Counter addresses never fault when the counters are absent (they behave as read-zero).
  assign w_illegal = bus.csr_r_en_i &
                     (~w_impl |
                      ((bus.csr_addr_i[11:10] == 2'b11) & w_is_write &
                       (CNT_EN | ~is_counter_addr(bus.csr_addr_i))));

  // A trap or mret in M flushes the X instruction, so its write never lands.
  assign w_we = bus.csr_r_en_i & w_is_write & ~w_illegal & ~w_flush;

  // M-stage result registers; a flushed instruction must not raise its own fault.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rdata <= 32'd0;
      r_exc   <= 1'b0;
    end else begin
      r_rdata <= bus.csr_r_en_i ? w_old : 32'd0;
      r_exc   <= w_illegal & ~w_flush;
    end
  end

  // Trap state: trap beats mret beats software write.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
      r_mepc   <= 32'd0;
      r_mcause <= 32'd0;
    end else if (w_take_trap) begin
      r_mepc   <= bus.excep_pc_i & ~32'h3;
      r_mcause <= bus.exception_i ? {28'd0, bus.excep_code_i} : MCAUSE_ILLEGAL_INSTR;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else if (w_mret) begin
      r_mie    <= r_mpie;
      r_mpie   <= 1'b1;
    end else if (w_we) begin
      case (bus.csr_addr_i)
        CSR_MSTATUS: begin
          r_mie  <= w_new[MSTATUS_MIE];
          r_mpie <= w_new[MSTATUS_MPIE];
        end
        CSR_MEPC:   r_mepc   <= w_new & ~32'h3;
        CSR_MCAUSE: r_mcause <= w_new;
        default: ;
      endcase
    end
  end

  // Plain software-only registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mtvec    <= MTVEC_RESET & ~32'h3;
      r_mscratch <= 32'd0;
    end else if (w_we) begin
      if (bus.csr_addr_i == CSR_MTVEC)    r_mtvec    <= w_new & ~32'h3;
      if (bus.csr_addr_i == CSR_MSCRATCH) r_mscratch <= w_new;
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] w_mcycle, w_minstret;

  csr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_en  (1'b1),
    .lo_we   (w_we & (bus.csr_addr_i == CSR_MCYCLE)),
    .hi_we   (w_we & (bus.csr_addr_i == CSR_MCYCLEH)),
    .wdata   (w_new),
    .count   (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_en  (bus.retire_i),
    .lo_we   (w_we & (bus.csr_addr_i == CSR_MINSTRET)),
    .hi_we   (w_we & (bus.csr_addr_i == CSR_MINSTRETH)),
    .wdata   (w_new),
    .count   (w_minstret)
  );

  // Counter halves, shared by the machine registers and their user shadows.
  always_comb begin
    w_cnt_rd = 32'd0;
    case (bus.csr_addr_i)
      CSR_MCYCLE,    CSR_CYCLE:    w_cnt_rd = w_mcycle[31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   w_cnt_rd = w_mcycle[63:32];
      CSR_MINSTRET,  CSR_INSTRET:  w_cnt_rd = w_minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: w_cnt_rd = w_minstret[63:32];
      default:                     w_cnt_rd = 32'd0;
    endcase
  end
`else
  logic w_unused_retire;
  assign w_unused_retire = bus.retire_i;
  assign w_cnt_rd        = 32'd0;
`endif

  assign bus.csr_rdata_o     = r_rdata;
  assign bus.csr_exception_o = r_exc;
  assign bus.trap_redirect_o = w_flush;
  assign bus.trap_pc_o       = w_take_trap ? r_mtvec : r_mepc;

endmodule

`default_nettype wire

// File: tb/tb_csr_unit.sv
// +----------------------------------------------------------------------+
// | Module     : tb_csr_unit                                             |
// | Description: Directed bench for csr_unit with a behavioural CSR      |
// |              model compared every cycle plus literal expectations.   |
// |              Honours CSR_COUNTERS_EN like the design.                |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_csr_unit;
  import csr_unit_pkg::*;

`ifdef CSR_COUNTERS_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  csr_unit_if bus ();

  csr_unit #(
    .HART_ID     (32'h0),
    .MTVEC_RESET (32'h0),
    .MISA_VAL    (32'h4000_0100)
  ) u_dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_rdata;
  bit          m_mie, m_mpie, m_exc;
  longint unsigned m_cyc, m_ins;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
      12'h301: return 32'h4000_0100;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hF14: return 32'h0;
      12'hB00, 12'hC00: return CNT ? m_cyc[31:0]  : 32'h0;
      12'hB80, 12'hC80: return CNT ? m_cyc[63:32] : 32'h0;
      12'hB02, 12'hC02: return CNT ? m_ins[31:0]  : 32'h0;
      12'hB82, 12'hC82: return CNT ? m_ins[63:32] : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_known(input logic [11:0] a);
    return a inside {12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF14,
                     12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82};
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [31:0] old, nv;
    logic [11:0] a;
    bit take, wr, ill, commit;
    longint unsigned n_cyc, n_ins;
    if (!rst_n) begin
      m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_rdata = 0;
      m_mie = 0; m_mpie = 0; m_exc = 0; m_cyc = 0; m_ins = 0;
    end else begin
      a    = bus.csr_addr_i;
      take = bus.exception_i || m_exc;
      old  = m_read(a);
      wr   = (bus.csr_op_mode_i == CSR_RW) ||
             ((bus.csr_op_mode_i != CSR_NONE) && (bus.csr_wdata_i != 0));
      case (bus.csr_op_mode_i)
        CSR_RW:  nv = bus.csr_wdata_i;
        CSR_SET: nv = old | bus.csr_wdata_i;
        CSR_CLR: nv = old & ~bus.csr_wdata_i;
        default: nv = old;
      endcase
      ill = bus.csr_r_en_i && (!m_known(a) ||
            (a >= 12'hC00 && wr && (CNT || !(a inside {12'hC00, 12'hC80, 12'hC02, 12'hC82}))));
      commit = bus.csr_r_en_i && wr && !ill && !take && !bus.ret_i;
      n_cyc = m_cyc + 1;
      n_ins = m_ins + (bus.retire_i ? 1 : 0);
      if (commit && CNT) begin
        if (a == 12'hB00) n_cyc = {m_cyc[63:32], nv};
        if (a == 12'hB80) n_cyc = {nv, m_cyc[31:0]};
        if (a == 12'hB02) n_ins = {m_ins[63:32], nv};
        if (a == 12'hB82) n_ins = {nv, m_ins[31:0]};
      end
      m_rdata = bus.csr_r_en_i ? old : 32'h0;
      if (take) begin
        m_mepc   = {bus.excep_pc_i[31:2], 2'b00};
        m_mcause = bus.exception_i ? 32'(bus.excep_code_i) : 32'd2;
        m_mpie   = m_mie;
        m_mie    = 0;
      end else if (bus.ret_i) begin
        m_mie  = m_mpie;
        m_mpie = 1;
      end else if (commit) begin
        case (a)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h305: m_mtvec    = {nv[31:2], 2'b00};
          12'h340: m_mscratch = nv;
          12'h341: m_mepc     = {nv[31:2], 2'b00};
          12'h342: m_mcause   = nv;
          default: ;
        endcase
      end
      m_exc = ill && !take && !bus.ret_i;
      m_cyc = n_cyc;
      m_ins = n_ins;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rdata", bus.csr_rdata_o, m_rdata);
      chk("csr_exc", {31'd0, bus.csr_exception_o}, {31'd0, m_exc});
      chk("redirect", {31'd0, bus.trap_redirect_o},
          {31'd0, bus.exception_i | m_exc | bus.ret_i});
      chk("trap_pc", bus.trap_pc_o, (bus.exception_i || m_exc) ? m_mtvec : m_mepc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.csr_r_en_i    = 0;
    bus.csr_op_mode_i = CSR_NONE;
    bus.csr_addr_i    = 0;
    bus.csr_wdata_i   = 0;
    bus.exception_i   = 0;
    bus.excep_code_i  = 0;
    bus.ret_i         = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one CSR instruction in X; on return csr_rdata_o holds its result.
  task automatic csr(input csr_op_mode_t op, input logic [11:0] a, input logic [31:0] d);
    bus.csr_r_en_i = 1; bus.csr_op_mode_i = op; bus.csr_addr_i = a; bus.csr_wdata_i = d;
    step();
    idle();
  endtask

  initial begin
    idle();
    bus.excep_pc_i = 32'h0;
    bus.retire_i   = 0;
    repeat (3) step();
    chk("rst_rdata", bus.csr_rdata_o, 32'h0);
    chk("rst_exc", {31'd0, bus.csr_exception_o}, 32'h0);
    chk("rst_trap_pc", bus.trap_pc_o, 32'h0);
    rst_n = 1;
    step();

    // mscratch write, then SET with zero operand is a pure read
    csr(CSR_RW, 12'h340, 32'hDEAD_BEEF);   chk("ms_rw_old", bus.csr_rdata_o, 32'h0);
    csr(CSR_SET, 12'h340, 32'h0);          chk("ms_set0", bus.csr_rdata_o, 32'hDEAD_BEEF);
    csr(CSR_CLR, 12'h340, 32'h0);          chk("ms_keep", bus.csr_rdata_o, 32'hDEAD_BEEF);
    step();
    chk("rdata_idle", bus.csr_rdata_o, 32'h0);

    // mstatus MIE set/clear
    csr(CSR_SET, 12'h300, 32'h8);          chk("mst_a", bus.csr_rdata_o, 32'h1800);
    csr(CSR_CLR, 12'h300, 32'h8);          chk("mst_b", bus.csr_rdata_o, 32'h1808);
    csr(CSR_SET, 12'h300, 32'h0);          chk("mst_c", bus.csr_rdata_o, 32'h1800);
    csr(CSR_RW, 12'h300, 32'hFFFF_FFFF);
    csr(CSR_RW, 12'h300, 32'h0);           chk("mst_mask", bus.csr_rdata_o, 32'h1888);

    // mtvec low bits forced to zero; misa is write-ignored without a fault
    csr(CSR_RW, 12'h305, 32'h203);
    csr(CSR_SET, 12'h305, 32'h0);          chk("mtvec", bus.csr_rdata_o, 32'h200);
    csr(CSR_RW, 12'h301, 32'h5);           chk("misa_exc", {31'd0, bus.csr_exception_o}, 32'h0);
    csr(CSR_SET, 12'h301, 32'h0);          chk("misa", bus.csr_rdata_o, 32'h4000_0100);

    // ecall trap with MIE=1
    csr(CSR_SET, 12'h300, 32'h8);
    bus.exception_i = 1; bus.excep_code_i = 4'hB; bus.excep_pc_i = 32'h104;
    #1;
    chk("trap_redir", {31'd0, bus.trap_redirect_o}, 32'h1);
    chk("trap_pc", bus.trap_pc_o, 32'h200);
    #1;
    step(); idle();
    csr(CSR_SET, 12'h342, 32'h0);          chk("mcause_B", bus.csr_rdata_o, 32'hB);
    csr(CSR_SET, 12'h341, 32'h0);          chk("mepc", bus.csr_rdata_o, 32'h104);
    csr(CSR_SET, 12'h300, 32'h0);          chk("mst_trap", bus.csr_rdata_o, 32'h1880);

    // mret
    bus.ret_i = 1;
    #1; chk("mret_pc", bus.trap_pc_o, 32'h104); #1;
    step(); idle();
    csr(CSR_SET, 12'h300, 32'h0);          chk("mst_mret", bus.csr_rdata_o, 32'h1888);

    // exception and ret together, with a CSR write in X that must be flushed
    bus.exception_i = 1; bus.excep_code_i = 4'h3; bus.excep_pc_i = 32'h20B; bus.ret_i = 1;
    bus.csr_r_en_i = 1; bus.csr_op_mode_i = CSR_RW; bus.csr_addr_i = 12'h340; bus.csr_wdata_i = 32'h55;
    #1; chk("both_pc", bus.trap_pc_o, 32'h200); #1;
    step(); idle();
    csr(CSR_SET, 12'h342, 32'h0);          chk("mcause_3", bus.csr_rdata_o, 32'h3);
    csr(CSR_SET, 12'h341, 32'h0);          chk("mepc_mask", bus.csr_rdata_o, 32'h208);
    csr(CSR_SET, 12'h340, 32'h0);          chk("ms_flushed", bus.csr_rdata_o, 32'hDEAD_BEEF);

    // write to read-only mhartid
    bus.excep_pc_i = 32'h33;
    csr(CSR_RW, 12'hF14, 32'h5);
    chk("ro_exc", {31'd0, bus.csr_exception_o}, 32'h1);
    chk("ro_pc", bus.trap_pc_o, 32'h200);
    step();
    chk("ro_exc_1cyc", {31'd0, bus.csr_exception_o}, 32'h0);
    csr(CSR_SET, 12'h342, 32'h0);          chk("mcause_2", bus.csr_rdata_o, 32'h2);
    csr(CSR_SET, 12'hF14, 32'h0);          chk("hartid", bus.csr_rdata_o, 32'h0);
    chk("hartid_exc", {31'd0, bus.csr_exception_o}, 32'h0);
    csr(CSR_SET, 12'h7C0, 32'h0);          chk("unimpl", {31'd0, bus.csr_exception_o}, 32'h1);
    step();

    // counters
    bus.retire_i = 1; step(); step(); bus.retire_i = 0; step(); bus.retire_i = 1; step();
    bus.retire_i = 0;
    csr(CSR_RW, 12'hB00, 32'hFFFF_FFFF);
    chk("cnt_wr_exc", {31'd0, bus.csr_exception_o}, 32'h0);
    step();
    csr(CSR_SET, 12'hB80, 32'h0);
    chk("mcycleh", bus.csr_rdata_o, CNT ? 32'h1 : 32'h0);
    csr(CSR_SET, 12'hB02, 32'h0);
    chk("minstret", bus.csr_rdata_o, CNT ? 32'h3 : 32'h0);
    csr(CSR_SET, 12'hC80, 32'h0);
    chk("cycleh", bus.csr_rdata_o, CNT ? 32'h1 : 32'h0);
    csr(CSR_RW, 12'hC00, 32'h1);
    chk("cycle_ro", {31'd0, bus.csr_exception_o}, CNT ? 32'h1 : 32'h0);
    step(); step();

    // asynchronous reset clears state immediately
    csr(CSR_SET, 12'h340, 32'h0);
    chk("pre_rst", bus.csr_rdata_o, 32'hDEAD_BEEF);
    rst_n = 0;
    #1;
    chk("async_rst", bus.csr_rdata_o, 32'h0);
    step(); step();
    rst_n = 1;
    step();
    csr(CSR_SET, 12'h340, 32'h0);          chk("ms_after_rst", bus.csr_rdata_o, 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
